can_rx_deframer: RTL
====================

Name: can_rx_deframer

Overview:
- Bit-level receive path for the team's CAN-style serial link. It is the counterpart of the byte transmitter that drives `can_tx`.
- Synchronises `can_rx` and hunts for start-of-frame after a bus-idle period. Samples each bit mid-period, removes stuff bits, assembles 8 data bits LSB-first and checks the stop bit.
- Presents received bytes to the host side with a one-cycle valid strobe, plus error strobes.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per bit period. Must be even and >= 4.
- IDLE_BITS, 3, consecutive recessive bit periods required on the bus before a SOF is accepted.
- STUFF_LEN, 5, run length of identical bits after which a complementary stuff bit is inserted.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- can_rx  input  1  serial bus input (1 = recessive, 0 = dominant). Asynchronous to clk.
- data_out  output  8  last correctly received byte.
- data_valid  output  1  one-cycle pulse; data_out updated in the same cycle.
- stuff_err  output  1  one-cycle pulse on stuff violation.
- form_err  output  1  one-cycle pulse on a dominant stop bit.
- busy  output  1  high while the FSM is in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - Sync flops are set to 1.
  - data_out=0; data_valid, stuff_err, form_err and busy are all 0.
  - State=IDLE, idle counter=0, bit/run counters=0.
  - Reset mid-frame abandons the frame with no error pulse and re-requires the full idle period.
- Input synchronisation: two-flop synchroniser. rx_s is the second flop and is the only value used internally.
- IDLE:
  - idle_cnt counts consecutive cycles with rx_s=1 and clears on rx_s=0. It saturates at IDLE_BITS*CLKS_PER_BIT (armed).
  - When armed and rx_s=0, go to SOF with cnt=0.
- SOF:
  - Sample at cnt=CLKS_PER_BIT/2-1.
  - Sample=1 is a glitch: return to IDLE with idle_cnt=0 and no error.
  - Sample=0 goes to DATA. Run tracking is initialised to value 0, length 1.
- DATA:
  - Samples are taken every CLKS_PER_BIT cycles after the previous sample point.
  - If run length==STUFF_LEN, the sample is a stuff bit:
    - Sample equal to the run value: pulse stuff_err, go to IDLE.
    - Otherwise discard the sample and restart the run with the stuff value, length 1.
  - Otherwise the sample is a data bit:
    - Shift it into the shift register at bit index bit_cnt (LSB first).
    - Update the run: same value increments the length, a different value restarts it at 1.
    - Increment bit_cnt.
  - After the 8th data bit, if run length==STUFF_LEN, exactly one more stuff bit is expected (same rules as above). Then go to STOP.
- STOP:
  - The next sample point is the stop bit. It is not subject to stuff checking.
  - Sample=1: in the following cycle data_out<=shift register and data_valid=1 for one cycle.
  - Sample=0: form_err=1 for one cycle and data_out is unchanged.
  - Either outcome goes to IDLE with idle_cnt=0.
- Pulse exclusivity: data_valid, stuff_err and form_err are mutually exclusive and never high for two consecutive cycles.
- can_rx is ignored outside IDLE except at sample points. Edges mid-bit have no effect; there is no resynchronisation.
- Counters: cnt is ceil(log2(CLKS_PER_BIT)) bits and wraps to 0 at CLKS_PER_BIT-1. bit_cnt is 4 bits. The run counter is 3 bits.

Test Plan (CLKS_PER_BIT=8, IDLE_BITS=3, each bit driven for 8 cycles):
- Byte 0xA5, no stuffing:
  - Stimulus: 24+ idle cycles high, then SOF 0, data 1,0,1,0,0,1,0,1, stop 1.
  - Required: exactly one data_valid with data_out=0xA5.
  - Required timing: data_valid lands 1 cycle after the stop sample, which is 2+3+72 cycles after the SOF falling edge on can_rx.
- Byte 0x00:
  - Stimulus: SOF 0, data 0,0,0,0, stuff 1, data 0,0,0,0, stop 1.
  - Required: data_valid with data_out=0x00; the stuff bit is discarded.
- Byte 0xFF:
  - Stimulus: SOF 0, data 1,1,1,1,1, stuff 0, data 1,1,1, stop 1.
  - Required: data_out=0xFF.
  - Repeat with 0x1F: data 1,1,1,1,1, stuff 0, data 0,0,0, stop 1. Required: data_out=0x1F.
- Stuff violation:
  - Stimulus: the 0x00 sequence with a 0 where the stuff bit belongs.
  - Required: one stuff_err pulse at that sample point, no data_valid, busy drops, data_out keeps its prior value.
- Form error:
  - Stimulus: 0xA5 frame with a stop bit of 0.
  - Required: one form_err pulse, no data_valid, data_out unchanged.
  - Next valid frame: not accepted until after 24 recessive cycles. An immediate SOF is ignored.
- Glitch and reset:
  - Stimulus 1: 3-cycle low pulse in armed IDLE. Required: SOF rejected, no pulses, idle count restarts.
  - Stimulus 2: reset asserted for 1 cycle mid-DATA of a 0x3C frame. Required: all outputs return to reset values, no pulses, and the next full 0x3C frame after idle is received correctly.

Source files
------------

// File: rtl/can_rx_deframer_if.sv
// Host-side bundle of the CAN-style receive deframer: serial input plus byte/strobe outputs.
// The deframer uses the master view; the host/bus model uses the slave view.
interface can_rx_deframer_if;
   logic       can_rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       stuff_err;
   logic       form_err;
   logic       busy;

   modport master (
      input  can_rx,
      output data_out,
      output data_valid,
      output stuff_err,
      output form_err,
      output busy
   );

   modport slave (
      output can_rx,
      input  data_out,
      input  data_valid,
      input  stuff_err,
      input  form_err,
      input  busy
   );
endinterface

// File: rtl/can_rx_deframer.sv
// Bit-level CAN-style receiver: waits for bus idle, samples mid-bit, strips stuff bits,
// assembles one LSB-first byte and checks the recessive stop bit.
module can_rx_deframer #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter int unsigned IDLE_BITS    = 3,
   parameter int unsigned STUFF_LEN    = 5
) (
   input  logic                clk,
   input  logic                reset,
   can_rx_deframer_if.master   bus_io
);

   localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
   localparam int unsigned IdleMax  = IDLE_BITS * CLKS_PER_BIT;
   localparam int unsigned IdleW    = $clog2(IdleMax + 1);
   localparam logic [CntW-1:0]  SofPt    = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0]  BitPt    = CntW'(CLKS_PER_BIT - 1);
   localparam logic [IdleW-1:0] IdleArm  = IdleW'(IdleMax);
   localparam logic [2:0]       StuffLen = 3'(STUFF_LEN);

   typedef enum logic [1:0] {StIdle, StSof, StData, StStop} state_e;

   state_e            state_q;
   logic              rx_meta_q, rx_s_q;
   logic [IdleW-1:0]  idle_cnt_q;
   logic [CntW-1:0]   cnt_q;
   logic [3:0]        bit_cnt_q;
   logic [2:0]        run_len_q;
   logic              run_val_q;
   logic [7:0]        shift_q;
   logic [7:0]        data_out_q;
   logic              data_valid_q, stuff_err_q, form_err_q, busy_q;

   // Run state the current sample would produce if it is taken as a data bit.
   logic [2:0] run_len_nx;
   logic       run_val_nx;

   always_comb begin
      run_val_nx = rx_s_q;
      run_len_nx = 3'd1;
      if (rx_s_q == run_val_q) begin
         run_val_nx = run_val_q;
         run_len_nx = run_len_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= bus_io.can_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         idle_cnt_q   <= '0;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         run_len_q    <= '0;
         run_val_q    <= 1'b0;
         shift_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         stuff_err_q  <= 1'b0;
         form_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         stuff_err_q  <= 1'b0;
         form_err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (rx_s_q) begin
                  if (idle_cnt_q != IdleArm) idle_cnt_q <= idle_cnt_q + 1'b1;
               end else begin
                  idle_cnt_q <= '0;
                  if (idle_cnt_q == IdleArm) begin
                     state_q <= StSof;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            StSof: begin
               if (cnt_q == SofPt) begin
                  cnt_q <= '0;
                  if (rx_s_q) begin
                     state_q    <= StIdle;
                     idle_cnt_q <= '0;
                     busy_q     <= 1'b0;
                  end else begin
                     state_q   <= StData;
                     run_val_q <= 1'b0;
                     run_len_q <= 3'd1;
                     bit_cnt_q <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StData: begin
               if (cnt_q == BitPt) begin
                  cnt_q <= '0;
                  if (run_len_q == StuffLen) begin
                     if (rx_s_q == run_val_q) begin
                        stuff_err_q <= 1'b1;
                        state_q     <= StIdle;
                        idle_cnt_q  <= '0;
                        busy_q      <= 1'b0;
                     end else begin
                        run_val_q <= rx_s_q;
                        run_len_q <= 3'd1;
                        if (bit_cnt_q == 4'd8) state_q <= StStop;
                     end
                  end else begin
                     shift_q[bit_cnt_q[2:0]] <= rx_s_q;
                     run_val_q <= run_val_nx;
                     run_len_q <= run_len_nx;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     // A trailing full run keeps us in DATA for one more (stuff) sample.
                     if (bit_cnt_q == 4'd7 && run_len_nx != StuffLen) state_q <= StStop;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (cnt_q == BitPt) begin
                  cnt_q      <= '0;
                  state_q    <= StIdle;
                  idle_cnt_q <= '0;
                  busy_q     <= 1'b0;
                  if (rx_s_q) begin
                     data_out_q   <= shift_q;
                     data_valid_q <= 1'b1;
                  end else begin
                     form_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.data_out   = data_out_q;
   assign bus_io.data_valid = data_valid_q;
   assign bus_io.stuff_err  = stuff_err_q;
   assign bus_io.form_err   = form_err_q;
   assign bus_io.busy       = busy_q;

endmodule
